gn_rst_seq_ctrl: RTL

- Synthesizable reset sequencer. It takes the board/bench active-low async reset and produces per-domain active-low resets.
- Assertion is asynchronous; release is synchronous.
- Release is staggered: domain 0 first, then each higher domain P_STEP_CYC cycles after the previous one.
- Supports a software-initiated reset re-sequence. Sits between the top-level reset source and all downstream clocked blocks.

---
 rtl/gn_rst_seq_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/gn_rst_seq_ctrl.sv
// Reset sequencer: async assert, 2..n-flop synchronized release, staggered per-domain release (bit k at P_SYNC_STG+P_HOLD_CYC+k*P_STEP_CYC edges).
// No backpressure; sw_rst_req is a level. Define GN_RST_SEQ_REV_ASSERT_EN for reverse-order soft assertion from ST_DONE.
`timescale 1ns/1ps
module gn_rst_seq_ctrl #(
  parameter int P_NUM_DOM  = 4,
  parameter int P_SYNC_STG = 2,
  parameter int P_HOLD_CYC = 16,
  parameter int P_STEP_CYC = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sw_rst_req,
  output logic [P_NUM_DOM-1:0] rst_out_n,
  output logic                 seq_busy,
  output logic                 seq_done
);

  localparam int LP_MAX_CYC = (P_HOLD_CYC > P_STEP_CYC) ? P_HOLD_CYC : P_STEP_CYC;
  localparam int LP_CW      = $clog2(LP_MAX_CYC) + 1;
  localparam logic [LP_CW-1:0] LP_HOLD_TC = LP_CW'(P_HOLD_CYC - 1);
  localparam logic [LP_CW-1:0] LP_STEP_TC = LP_CW'(P_STEP_CYC - 1);
  localparam logic [LP_CW-1:0] LP_ONE     = LP_CW'(1);

  if (P_NUM_DOM < 1 || P_NUM_DOM > 16) begin : g_bad_num_dom
    $error("gn_rst_seq_ctrl: P_NUM_DOM must be 1..16");
  end
  if (P_SYNC_STG < 2) begin : g_bad_sync_stg
    $error("gn_rst_seq_ctrl: P_SYNC_STG must be >= 2");
  end
  if (P_HOLD_CYC < 1) begin : g_bad_hold_cyc
    $error("gn_rst_seq_ctrl: P_HOLD_CYC must be >= 1");
  end
  if (P_STEP_CYC < 1) begin : g_bad_step_cyc
    $error("gn_rst_seq_ctrl: P_STEP_CYC must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
`ifdef GN_RST_SEQ_REV_ASSERT_EN
    ST_DONE    = 2'd2,
    ST_ASSERT  = 2'd3
`else
    ST_DONE    = 2'd2
`endif
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [LP_CW-1:0]       r_cnt;
  logic [LP_CW-1:0]       w_cnt_nxt;
  logic [P_NUM_DOM-1:0]   r_rst_n;
  logic [P_NUM_DOM-1:0]   w_rst_nxt;
  logic [P_NUM_DOM-1:0]   w_rel_shift;
  logic                   r_busy;
  logic                   w_busy_nxt;
  logic                   r_done;
  logic                   w_done_nxt;
  logic [P_SYNC_STG-1:0]  r_sync;
  logic                   w_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[P_SYNC_STG-2:0], 1'b1};
    end
  end

  assign w_sync = r_sync[P_SYNC_STG-1];

  // Releasing the next domain shifts a 1 in from the bottom, keeping the 0..01..1 shape.
  always_comb begin
    w_rel_shift = {P_NUM_DOM{1'b1}};
    for (int k = 1; k < P_NUM_DOM; k++) begin
      w_rel_shift[k] = r_rst_n[k-1];
    end
  end

`ifdef GN_RST_SEQ_REV_ASSERT_EN
  logic [P_NUM_DOM-1:0] w_ast_shift;

  // Reverse assertion shifts a 0 in from the top domain downward.
  always_comb begin
    w_ast_shift = '0;
    for (int k = 0; k < P_NUM_DOM - 1; k++) begin
      w_ast_shift[k] = r_rst_n[k+1];
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_HOLD;
      r_cnt   <= '0;
      r_rst_n <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rst_n <= w_rst_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rst_nxt   = r_rst_n;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    case (r_state)
      ST_HOLD: begin
        if (!w_sync || sw_rst_req) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == LP_HOLD_TC) begin
          w_cnt_nxt = '0;
          w_rst_nxt = w_rel_shift;
          if (&w_rel_shift) begin
            w_state_nxt = ST_DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_RELEASE;
          end
        end else begin
          w_cnt_nxt = r_cnt + LP_ONE;
        end
      end

      ST_RELEASE: begin
        if (sw_rst_req) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
          w_rst_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
        end else if (r_cnt == LP_STEP_TC) begin
          w_cnt_nxt = '0;
          w_rst_nxt = w_rel_shift;
          if (&w_rel_shift) begin
            w_state_nxt = ST_DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + LP_ONE;
        end
      end

      ST_DONE: begin
        if (sw_rst_req) begin
          w_cnt_nxt  = '0;
          w_busy_nxt = 1'b1;
          w_done_nxt = 1'b0;
`ifdef GN_RST_SEQ_REV_ASSERT_EN
          w_rst_nxt  = w_ast_shift;
          // A single-domain build has nothing left to stagger.
          w_state_nxt = (w_ast_shift == '0) ? ST_HOLD : ST_ASSERT;
`else
          w_rst_nxt   = '0;
          w_state_nxt = ST_HOLD;
`endif
        end
      end

`ifdef GN_RST_SEQ_REV_ASSERT_EN
      ST_ASSERT: begin
        if (r_cnt == LP_STEP_TC) begin
          w_cnt_nxt = '0;
          w_rst_nxt = w_ast_shift;
          if (w_ast_shift == '0) begin
            w_state_nxt = ST_HOLD;
          end
        end else begin
          w_cnt_nxt = r_cnt + LP_ONE;
        end
      end
`endif

      default: begin
        w_state_nxt = ST_HOLD;
        w_cnt_nxt   = '0;
        w_rst_nxt   = '0;
        w_busy_nxt  = 1'b1;
        w_done_nxt  = 1'b0;
      end
    endcase
  end

  assign rst_out_n = r_rst_n;
  assign seq_busy  = r_busy;
  assign seq_done  = r_done;

endmodule
